sm_addsub_seq: RTL and testbench

- Multi-cycle sign-magnitude add/subtract unit that reuses one instance of the team's N-bit ripple-carry adder, `full_adder` (parameter N, ports a, b, cin, cout, sum).
- The adder is used across one or two passes: one pass for the add or the magnitude subtract, and an optional second pass to negate a borrowed result.
- Operands are accepted through a valid/ready handshake; results are returned through a separate valid/ready handshake.
- Sits between the operand-issue logic and the result consumer.

---
 rtl/sm_addsub_seq.sv | 168 ++++++++++++++++
 tb/tb_sm_addsub_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_addsub_seq.sv
// Multi-cycle sign-magnitude add/subtract unit built around a single shared
// ripple-carry adder, with valid/ready handshakes on operands and results.

module full_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         cout,
    output logic [N-1:0] sum
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];
endmodule

module sm_addsub_seq #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic [N-1:0]     a_mag,
    input  logic             b_sign,
    input  logic [N-1:0]     b_mag,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic [N-1:0]     res_mag,
    output logic             ovf,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready only in IDLE, out_valid only in DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic             a_sign_q;
    logic [N-1:0]     a_mag_q;
    logic [N-1:0]     b_mag_q;
    logic             eb_q;
    logic [N-1:0]     tmp_q;
    logic             res_sign_q;
    logic [N-1:0]     res_mag_q;
    logic             ovf_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;

    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic         add_cout;
    logic [N-1:0] add_sum;
    logic         sub_path;
    logic         sum_nz;

    assign sub_path = a_sign_q ^ eb_q;
    assign sum_nz   = |add_sum;

    // Operand steering for the shared adder: plain add, A + ~B + 1, or
    // two's-complement negation of the borrowed difference.
    always_comb begin
        add_a   = a_mag_q;
        add_b   = b_mag_q;
        add_cin = 1'b0;
        if (state_q == CALC && sub_path) begin
            add_b   = ~b_mag_q;
            add_cin = 1'b1;
        end else if (state_q == FIX) begin
            add_a   = ~tmp_q;
            add_b   = '0;
            add_cin = 1'b1;
        end
    end

    full_adder #(.N(N)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .cout (add_cout),
        .sum  (add_sum)
    );

    assign op_count_d = op_count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sign_q   <= 1'b0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            eb_q       <= 1'b0;
            tmp_q      <= '0;
            res_sign_q <= 1'b0;
            res_mag_q  <= '0;
            ovf_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sign_q <= a_sign;
                        a_mag_q  <= a_mag;
                        b_mag_q  <= b_mag;
                        eb_q     <= b_sign ^ op;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    if (!sub_path) begin
                        // An overflowed wrap to zero keeps the operand sign.
                        res_mag_q  <= add_sum;
                        ovf_q      <= add_cout;
                        res_sign_q <= a_sign_q & (add_cout | sum_nz);
                        state_q    <= DONE;
                    end else if (add_cout) begin
                        res_mag_q  <= add_sum;
                        ovf_q      <= 1'b0;
                        res_sign_q <= a_sign_q & sum_nz;
                        state_q    <= DONE;
                    end else begin
                        tmp_q   <= add_sum;
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    res_mag_q  <= add_sum;
                    ovf_q      <= 1'b0;
                    res_sign_q <= eb_q & sum_nz;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        op_count_q <= op_count_d;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res_sign  = res_sign_q;
    assign res_mag   = res_mag_q;
    assign ovf       = ovf_q;
    assign op_count  = op_count_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_sm_addsub_seq.sv
// Scoreboard bench for sm_addsub_seq: an independent integer model predicts
// each result and its latency; results are popped and compared at handshake.

module tb_sm_addsub_seq;
    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int MOD   = 1 << N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             a_sign;
    logic [N-1:0]     a_mag;
    logic             b_sign;
    logic [N-1:0]     b_mag;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic             res_sign;
    logic [N-1:0]     res_mag;
    logic             ovf;
    logic [CNT_W-1:0] op_count;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N+1:0]     exp_q[$];
    logic [CNT_W-1:0] exp_count;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sm_addsub_seq #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sign    (a_sign),
        .a_mag     (a_mag),
        .b_sign    (b_sign),
        .b_mag     (b_mag),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sign  (res_sign),
        .res_mag   (res_mag),
        .ovf       (ovf),
        .op_count  (op_count),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {fix, ovf, sign, mag}.
    function automatic logic [N+2:0] model(input logic sa, input int ma, input logic sb,
                                           input int mb, input logic o);
        logic eb;
        int   s;
        logic f;
        logic v;
        logic sg;
        eb = sb ^ o;
        f  = 1'b0;
        v  = 1'b0;
        if (sa == eb) begin
            s  = ma + mb;
            v  = (s >= MOD);
            s  = s % MOD;
            sg = v ? sa : ((s == 0) ? 1'b0 : sa);
        end else if (ma >= mb) begin
            s  = ma - mb;
            sg = (s == 0) ? 1'b0 : sa;
        end else begin
            s  = mb - ma;
            sg = eb;
            f  = 1'b1;
        end
        return {f, v, sg, N'(s)};
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic sa, input int ma, input logic sb, input int mb,
                          input logic o, input int hold, input logic poke);
        logic [N+2:0] m;
        logic [N+1:0] exp;
        logic [N+1:0] snap;
        int           lat;
        int           budget;
        m = model(sa, ma, sb, mb, o);
        exp_q.push_back(m[N+1:0]);

        @(negedge clk);
        in_valid = 1'b1;
        a_sign = sa; a_mag = N'(ma); b_sign = sb; b_mag = N'(mb); op = o;
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_val("accept_timeout", 32'(budget < 20), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_sign = 1'($urandom_range(0, 1)); a_mag = N'($urandom_range(0, MOD - 1));
        b_sign = 1'($urandom_range(0, 1)); b_mag = N'($urandom_range(0, MOD - 1));
        op     = 1'($urandom_range(0, 1));

        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), m[N+2] ? 32'd2 : 32'd1);
        if (lat >= 8) begin
            void'(exp_q.pop_front());
            return;
        end

        snap = {ovf, res_sign, res_mag};
        for (int i = 0; i < hold; i++) begin
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_val("hold_stable", 32'({ovf, res_sign, res_mag}), 32'(snap));
            check_val("hold_count", 32'(op_count), 32'(exp_count));
            if (poke && i == 0) begin
                in_valid = 1'b1;
                a_sign = 1'b1; a_mag = 4'd9; b_sign = 1'b0; b_mag = 4'd1; op = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("out_valid", 32'(out_valid), 32'd1);
        exp = exp_q.pop_front();
        check_val("result", 32'({ovf, res_sign, res_mag}), 32'(exp));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_count = exp_count + CNT_W'(1);
        @(negedge clk);
        check_val("op_count", 32'(op_count), 32'(exp_count));
        check_val("in_ready_after", 32'(in_ready), 32'd1);
        check_val("out_valid_after", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_outs"}, 32'({out_valid, ovf, res_sign, res_mag}), 32'd0);
        check_val({tag, "_count"}, 32'(op_count), 32'd0);
        check_val({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_sign = 1'b0; a_mag = '0; b_sign = 1'b0; b_mag = '0; op = 1'b0;
        exp_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_in_ready", 32'(in_ready), 32'd0);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("in_ready_idle", 32'(in_ready), 32'd1);

        run_op(1'b0, 5,  1'b0, 3,  1'b0, 0, 1'b0);  // +5 + +3 = +8
        run_op(1'b0, 7,  1'b1, 3,  1'b0, 0, 1'b0);  // +7 + -3 = +4
        run_op(1'b0, 3,  1'b1, 7,  1'b0, 0, 1'b0);  // +3 + -7 = -4, FIX pass
        run_op(1'b0, 12, 1'b0, 9,  1'b0, 0, 1'b0);  // overflow -> 5
        run_op(1'b1, 5,  1'b0, 5,  1'b0, 0, 1'b0);  // -5 + +5 = +0
        run_op(1'b0, 5,  1'b0, 5,  1'b1, 0, 1'b0);  // +5 - +5 = +0
        run_op(1'b1, 0,  1'b1, 0,  1'b0, 0, 1'b0);  // -0 + -0 = +0
        run_op(1'b1, 2,  1'b0, 6,  1'b1, 0, 1'b0);  // -2 - +6 = -8
        run_op(1'b0, 5,  1'b0, 3,  1'b0, 3, 1'b1);  // backpressure with ignored request

        // Reset while the FIX pass is in flight.
        @(negedge clk);
        in_valid = 1'b1;
        a_sign = 1'b0; a_mag = 4'd3; b_sign = 1'b1; b_mag = 4'd7; op = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("in_fix", 32'(state_dbg), 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_count = '0;
        @(negedge clk);
        check_reset_outputs("midrst");
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        run_op(1'b0, 2, 1'b0, 2, 1'b0, 0, 1'b0);   // +2 + +2 = +4

        for (int k = 0; k < 24; k++) begin
            run_op(1'($urandom_range(0, 1)), $urandom_range(0, MOD - 1),
                   1'($urandom_range(0, 1)), $urandom_range(0, MOD - 1),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)));
        end

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
